// File: rtl/ollar_mem_arbiter_if.sv
// Bundle of the four-core request side and the single memory port of the
// OLLAR shared-memory arbiter. The arbiter uses the slave modport. The
// requesting cores together with the memory use the master modport.
interface ollar_mem_arbiter_if #(
    parameter int N_CORES = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
);
    logic [N_CORES-1:0]        core_req;
    logic [N_CORES-1:0]        core_we;
    logic [N_CORES*ADDR_W-1:0] core_addr;
    logic [N_CORES*DATA_W-1:0] core_wdata;
    logic [N_CORES-1:0]        core_ack;
    logic [DATA_W-1:0]         core_rdata;
    logic                      mem_en;
    logic                      mem_we;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_wdata;
    logic [DATA_W-1:0]         mem_rdata;
    logic [1:0]                grant_id;
    logic                      busy;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata, mem_rdata,
        output core_ack, core_rdata, mem_en, mem_we, mem_addr, mem_wdata,
               grant_id, busy
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata, mem_rdata,
        input  core_ack, core_rdata, mem_en, mem_we, mem_addr, mem_wdata,
               grant_id, busy
    );
endinterface

// File: rtl/ollar_mem_arbiter.sv
// Round-robin arbiter for four OLLAR cores sharing one fixed-latency memory
// port. It handles one access at a time: IDLE arbitrates, ISSUE strobes
// mem_en, WAIT counts down the memory latency, and RESP pulses the ack.
module ollar_mem_arbiter #(
    parameter int N_CORES     = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1
) (
    input logic               CLOCK_PIN,
    input logic               RESET_PIN,
    ollar_mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [1:0]          ptr_r;
    logic [3:0]          cnt_r;
    logic [1:0]          grant_s;
    logic                any_req_s;
    logic [1:0]          grant_r;
    logic                mem_en_r;
    logic                mem_we_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [DATA_W-1:0]   mem_wdata_r;
    logic [DATA_W-1:0]   core_rdata_r;
    logic [N_CORES-1:0]  core_ack_r;
    logic                busy_r;

    // The first requester found at or after ptr wins. Scanning downward lets
    // the closest candidate overwrite any farther one.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [2:0] pick;
        logic [1:0] idx;
        pick = 3'b000;
        idx  = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) begin
                pick = {1'b1, idx};
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    // Round-robin grant candidate, examined only while IDLE.
    always_comb begin
        any_req_s = 1'b0;
        grant_s   = 2'd0;
        {any_req_s, grant_s} = rr_pick(bus.core_req, ptr_r);
    end

    // Next-state logic. RESP always returns to IDLE, so a request that is
    // still high in its ack cycle is never issued a second time.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) state_s = ST_ISSUE;
                else           state_s = ST_IDLE;
            end
            ST_ISSUE: state_s = ST_WAIT;
            ST_WAIT: begin
                if (cnt_r == 4'd0) state_s = ST_RESP;
                else               state_s = ST_WAIT;
            end
            ST_RESP: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLOCK_PIN) begin
        if (RESET_PIN) state_r <= ST_IDLE;
        else           state_r <= state_s;
    end

    // Datapath registers. An aborted access gets no ack after reset. The
    // memory-side fields hold their values from one ISSUE to the next.
    always_ff @(posedge CLOCK_PIN) begin
        if (RESET_PIN) begin
            ptr_r        <= 2'd0;
            cnt_r        <= 4'd0;
            grant_r      <= 2'd0;
            mem_en_r     <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_wdata_r  <= {DATA_W{1'b0}};
            core_rdata_r <= {DATA_W{1'b0}};
            core_ack_r   <= {N_CORES{1'b0}};
            busy_r       <= 1'b0;
        end else begin
            mem_en_r   <= 1'b0;
            core_ack_r <= {N_CORES{1'b0}};
            busy_r     <= (state_s != ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    if (any_req_s) begin
                        grant_r     <= grant_s;
                        mem_en_r    <= 1'b1;
                        mem_we_r    <= bus.core_we[grant_s];
                        mem_addr_r  <= bus.core_addr[int'(grant_s)*ADDR_W +: ADDR_W];
                        mem_wdata_r <= bus.core_wdata[int'(grant_s)*DATA_W +: DATA_W];
                    end
                end
                ST_ISSUE: cnt_r <= 4'(MEM_LATENCY - 1);
                ST_WAIT: begin
                    if (cnt_r == 4'd0) begin
                        if (!mem_we_r) core_rdata_r <= bus.mem_rdata;
                        core_ack_r <= N_CORES'(1) << grant_r;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_RESP: ptr_r <= grant_r + 2'd1;
                default: ;
            endcase
        end
    end

    assign bus.core_ack   = core_ack_r;
    assign bus.core_rdata = core_rdata_r;
    assign bus.mem_en     = mem_en_r;
    assign bus.mem_we     = mem_we_r;
    assign bus.mem_addr   = mem_addr_r;
    assign bus.mem_wdata  = mem_wdata_r;
    assign bus.grant_id   = grant_r;
    assign bus.busy       = busy_r;

endmodule

// File: tb/tb_ollar_mem_arbiter.sv
// Directed bench for ollar_mem_arbiter. DUT a uses MEM_LATENCY=1 and DUT b
// uses MEM_LATENCY=4. Each memory model returns data only after the exact
// latency, so a wrong sample point reads the filler pattern instead.
module tb_ollar_mem_arbiter;

    localparam logic [31:0] FILL = 32'hBAD0_BAD0;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   last_en;

    ollar_mem_arbiter_if #(.N_CORES(4), .ADDR_W(32), .DATA_W(32)) bus_a ();
    ollar_mem_arbiter_if #(.N_CORES(4), .ADDR_W(32), .DATA_W(32)) bus_b ();

    ollar_mem_arbiter #(.N_CORES(4), .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) dut_a (
        .CLOCK_PIN(clk), .RESET_PIN(rst_a), .bus(bus_a.slave));
    ollar_mem_arbiter #(.N_CORES(4), .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(4)) dut_b (
        .CLOCK_PIN(clk), .RESET_PIN(rst_b), .bus(bus_b.slave));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
        else                    return a ^ 32'h5A5A_0000;
    endfunction

    // Memory for DUT a: read data appears one cycle after mem_en.
    always @(posedge clk)
        bus_a.mem_rdata <= (bus_a.mem_en && !bus_a.mem_we) ? mem_val(bus_a.mem_addr) : FILL;

    // Memory for DUT b: four-stage read pipeline.
    logic [31:0] pipe_b [0:3];
    always @(posedge clk) begin
        pipe_b[0] <= (bus_b.mem_en && !bus_b.mem_we) ? mem_val(bus_b.mem_addr) : FILL;
        for (int i = 1; i < 4; i++) pipe_b[i] <= pipe_b[i-1];
    end
    assign bus_b.mem_rdata = pipe_b[3];

    task automatic check_value(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in an IDLE cycle that has the granted request present. Returns
    // in the IDLE cycle that follows the ack.
    task automatic run_txn(input string tag, input logic [1:0] g, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata_exp, input logic drop, input logic chk_gap);
        check_value({tag, "_idle_busy"}, 64'(bus_a.busy), 64'd0);
        step();
        check_value({tag, "_issue_en_we"}, 64'({bus_a.mem_en, bus_a.mem_we}), 64'({1'b1, we}));
        check_value({tag, "_issue_addr"}, 64'(bus_a.mem_addr), 64'(addr));
        check_value({tag, "_issue_wdata"}, 64'(bus_a.mem_wdata), 64'(wdata));
        check_value({tag, "_grant"}, 64'({bus_a.grant_id, bus_a.busy, bus_a.core_ack}),
                    64'({g, 1'b1, 4'b0000}));
        if (chk_gap) check_value({tag, "_en_gap"}, 64'(cyc - last_en), 64'd4);
        last_en = cyc;
        step();
        check_value({tag, "_wait"}, 64'({bus_a.mem_en, bus_a.core_ack, bus_a.busy}),
                    64'({1'b0, 4'b0000, 1'b1}));
        step();
        check_value({tag, "_ack"}, 64'(bus_a.core_ack), 64'(4'b0001 << g));
        check_value({tag, "_rdata"}, 64'(bus_a.core_rdata), 64'(rdata_exp));
        step();
        check_value({tag, "_post"}, 64'({bus_a.core_ack, bus_a.busy, bus_a.mem_en}), 64'd0);
        if (drop) bus_a.core_req[g] = 1'b0;
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        last_en = 0;
        bus_a.core_req = 4'b1111;
        bus_a.core_we  = 4'b0000;
        bus_b.core_req = 4'b0000;
        bus_b.core_we  = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            bus_a.core_addr[i*32 +: 32]  = 32'h0000_1000 + 32'(i) * 32'h10;
            bus_a.core_wdata[i*32 +: 32] = 32'h1111_1111 * 32'(i + 1);
            bus_b.core_addr[i*32 +: 32]  = 32'h0000_0300 + 32'(i) * 32'h10;
            bus_b.core_wdata[i*32 +: 32] = 32'h0;
        end

        // Reset held two cycles with every core requesting.
        for (int r = 0; r < 2; r++) begin
            step();
            check_value("rst_outputs",
                        {bus_a.mem_en, bus_a.mem_we, bus_a.core_ack, bus_a.busy, bus_a.grant_id,
                         bus_a.mem_addr[15:0], bus_a.core_rdata[15:0]}, 64'd0);
        end
        rst_a = 1'b0;

        // All four request together; grants run 0,1,2,3 one per transaction.
        for (int g = 0; g < 4; g++)
            run_txn("all4", 2'(g), 1'b0, 32'h0000_1000 + 32'(g) * 32'h10,
                    32'h1111_1111 * 32'(g + 1), mem_val(32'h0000_1000 + 32'(g) * 32'h10),
                    1'b1, g != 0);

        // Core 2 load from 0x100.
        bus_a.core_addr[2*32 +: 32] = 32'h0000_0100;
        bus_a.core_req[2] = 1'b1;
        run_txn("load2", 2'd2, 1'b0, 32'h0000_0100, 32'h3333_3333, 32'hDEAD_BEEF, 1'b1, 1'b0);

        // Core 1 store; core_rdata must keep the previous load data.
        bus_a.core_addr[1*32 +: 32]  = 32'h0000_0020;
        bus_a.core_wdata[1*32 +: 32] = 32'h0000_0055;
        bus_a.core_we[1]  = 1'b1;
        bus_a.core_req[1] = 1'b1;
        run_txn("store1", 2'd1, 1'b1, 32'h0000_0020, 32'h0000_0055, 32'hDEAD_BEEF, 1'b1, 1'b0);
        bus_a.core_we[1] = 1'b0;

        // Reset in IDLE returns the pointer to 0. Cores 0 and 3 then keep
        // requesting and must alternate.
        rst_a = 1'b1;
        step();
        check_value("rst_idle", {bus_a.core_rdata, bus_a.mem_addr}, 64'd0);
        rst_a = 1'b0;
        bus_a.core_req = 4'b1001;
        for (int k = 0; k < 4; k++)
            run_txn("alt03", (k % 2 == 0) ? 2'd0 : 2'd3, 1'b0,
                    (k % 2 == 0) ? 32'h0000_1000 : 32'h0000_1030, (k % 2 == 0) ? 32'h1111_1111 : 32'h4444_4444,
                    mem_val((k % 2 == 0) ? 32'h0000_1000 : 32'h0000_1030), 1'b0, k != 0);
        bus_a.core_req = 4'b0000;

        // MEM_LATENCY=4: reset taken in WAIT aborts the access without an ack.
        rst_b = 1'b0;
        bus_b.core_req[1] = 1'b1;
        step();
        check_value("b_issue", {bus_b.mem_en, bus_b.grant_id, bus_b.mem_addr}, {1'b1, 2'd1, 32'h0000_0310});
        step();
        step();
        check_value("b_wait", {bus_b.busy, bus_b.core_ack}, {1'b1, 4'b0000});
        rst_b = 1'b1;
        step();
        check_value("b_rst", {bus_b.core_ack, bus_b.busy, bus_b.mem_en, bus_b.grant_id, bus_b.mem_addr}, 64'd0);
        bus_b.core_req[1] = 1'b0;
        step();
        check_value("b_rst_hold", {bus_b.core_ack, bus_b.busy}, 64'd0);
        rst_b = 1'b0;
        bus_b.core_req[3] = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            step();
            check_value("b_ack_timing", {bus_b.core_ack, bus_b.mem_en},
                        {(c == 6) ? 4'b1000 : 4'b0000, (c == 1) ? 1'b1 : 1'b0});
        end
        check_value("b_rdata", {bus_b.grant_id, bus_b.core_rdata}, {2'd3, mem_val(32'h0000_0330)});
        bus_b.core_req[3] = 1'b0;
        step();
        check_value("b_done", {bus_b.core_ack, bus_b.busy}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
